irq_ctrl: RTL

- Programmable interrupt controller between the peripheral IRQ lines (timer, input port, output port, spares) and the CPU's 6-bit HWInt input to CP0.
- Latches requests, applies per-line mask and edge/level mode, and picks the highest-priority line.
- Runs an acknowledge/EOI handshake so only one interrupt is in service at a time.
- Sits as one more bridge slave at base 0x0000_7F20.

---
 rtl/irq_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl: programmable interrupt controller on the bridge at BASE (PEND/MASK/MODE/ID/EOI).
// Optional: define IRQ_SYNC_EN to pass dev_irq through a 2-flop synchronizer first.
module irq_ctrl #(
    parameter int unsigned NLINE = 6,
    parameter logic [31:0] BASE  = 32'h0000_7F20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NLINE-1:0] dev_irq,
    input  logic [31:0]      addr,
    input  logic [31:0]      wd,
    input  logic             we,
    input  logic             re,
    output logic [31:0]      rd,
    output logic             hit,
    output logic [5:0]       HWInt
);
    typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

    state_t           state_q, state_d;
    logic [NLINE-1:0] pend_q, pend_d, mask_q, mask_d, mode_q, mode_d;
    logic [NLINE-1:0] isr_q, isr_d, irq_q, dev_s, req, w1c;
    logic [2:0]       idx_q, idx_d, sel_idx;
    logic [5:0]       hwint_q, hwint_d;
    logic [31:0]      off;
    logic             sel_pend, sel_mask, sel_mode, sel_id, sel_eoi, sel_any, ack;
    logic             unused_wd;

    assign unused_wd = ^wd[31:NLINE];

`ifdef IRQ_SYNC_EN
    logic [NLINE-1:0] sync1_q, sync2_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= dev_irq;
            sync2_q <= sync1_q;
        end
    end
    assign dev_s = sync2_q;
`else
    assign dev_s = dev_irq;
`endif

    always_comb begin
        off      = addr - BASE;
        hit      = (addr >= BASE) && (addr <= BASE + 32'h10);
        sel_pend = hit && (off == 32'h00);
        sel_mask = hit && (off == 32'h04);
        sel_mode = hit && (off == 32'h08);
        sel_id   = hit && (off == 32'h0C);
        sel_eoi  = hit && (off == 32'h10);
        rd       = '0;
        if (sel_pend) rd[NLINE-1:0] = pend_q;
        if (sel_mask) rd[NLINE-1:0] = mask_q;
        if (sel_mode) rd[NLINE-1:0] = mode_q;
        if (sel_id)   rd = {state_q == REQ, 28'b0, idx_q};
    end

    // Lowest enabled pending index wins.
    always_comb begin
        req     = pend_q & mask_q;
        sel_any = 1'b0;
        sel_idx = '0;
        for (int unsigned i = 0; i < NLINE; i++) begin
            if (req[i] && !sel_any) begin
                sel_any = 1'b1;
                sel_idx = 3'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        isr_d   = isr_q;
        hwint_d = '0;
        ack     = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_any) begin
                    state_d = REQ;
                    idx_d   = sel_idx;
                    hwint_d = 6'd1 << sel_idx;
                end
            end
            REQ: begin
                // An acknowledge already returned a valid idx, so it beats a same-cycle drop.
                if (re && sel_id) begin
                    ack          = 1'b1;
                    isr_d[idx_q] = 1'b1;
                    state_d      = SERV;
                end else if (!mask_q[idx_q] || !pend_q[idx_q]) begin
                    state_d = IDLE;
                end else begin
                    hwint_d = 6'd1 << idx_q;
                end
            end
            SERV: begin
                if (we && sel_eoi) begin
                    isr_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        w1c    = (we && sel_pend) ? wd[NLINE-1:0] : '0;
        mask_d = (we && sel_mask) ? wd[NLINE-1:0] : mask_q;
        mode_d = (we && sel_mode) ? wd[NLINE-1:0] : mode_q;
        pend_d = '0;
        for (int unsigned i = 0; i < NLINE; i++) begin
            // Level lines use next-cycle ISR so they drop at acknowledge and re-pend at EOI.
            if (mode_q[i])
                pend_d[i] = (pend_q[i] & ~w1c[i] & ~(ack && (idx_q == 3'(i))))
                          | (dev_s[i] & ~irq_q[i]);
            else
                pend_d[i] = dev_s[i] & ~isr_d[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            mask_q  <= '0;
            mode_q  <= '0;
            isr_q   <= '0;
            irq_q   <= '0;
            idx_q   <= '0;
            hwint_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            mode_q  <= mode_d;
            isr_q   <= isr_d;
            irq_q   <= dev_s;
            idx_q   <= idx_d;
            hwint_q <= hwint_d;
        end
    end

    assign HWInt = hwint_q;
endmodule
